regfile_mp: RTL and testbench

Parametrised multi-read-port register file: the successor to the 32x32 two-read-port bank in the RV32I multicycle datapath. It adds a configurable read-port count, a hardwired-zero register 0, and an async-reset-triggered clear sequencer that zeroes the array one word per cycle behind a `ready_o` flag. It also supports optional same-cycle write-through bypass. It sits between the writeback mux and the ALU operand latches.

---
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with hardwired x0 and a word-per-cycle clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int DATA_WIDTH  = 32,
  parameter int WORDS       = 32,
  parameter int SELECT_SIZE = 5,
  parameter int READ_PORTS  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              reg_we_ni,
  input  logic [SELECT_SIZE-1:0]            reg_dst_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic [READ_PORTS*SELECT_SIZE-1:0] reg_src_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  src_o,
  output logic                              ready_o,
  output logic                              wr_drop_o
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [SELECT_SIZE-1:0] CNT_ONE  = SELECT_SIZE'(1);
  localparam logic [SELECT_SIZE-1:0] CNT_LAST = SELECT_SIZE'(WORDS - 1);

  state_e                 state_q, state_d;
  logic [SELECT_SIZE-1:0] cnt_q, cnt_d;
  logic                   wr_drop_q, wr_drop_d;

  logic [DATA_WIDTH-1:0]  bank_q [WORDS];
  logic                   bank_we;
  logic [SELECT_SIZE-1:0] bank_waddr;
  logic [DATA_WIDTH-1:0]  bank_wdata;
  logic                   wr_req;

  assign wr_req = ~reg_we_ni;

  // Clear always wins: a write coinciding with CLEAR or clear_i is discarded and flagged.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_drop_d  = 1'b0;
    bank_we    = 1'b0;
    bank_waddr = cnt_q;
    bank_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        wr_drop_d = wr_req;
        if (clear_i) begin
          cnt_d = CNT_ONE;
        end else begin
          bank_we = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          cnt_d     = CNT_ONE;
          wr_drop_d = wr_req;
        end else if (wr_req && (reg_dst_i != '0)) begin
          bank_we    = 1'b1;
          bank_waddr = reg_dst_i;
          bank_wdata = data_i;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = CNT_ONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= CNT_ONE;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // The array itself carries no reset; the sequencer zeroes it after reset instead.
  always_ff @(posedge clk_i) begin
    if (bank_we) begin
      bank_q[bank_waddr] <= bank_wdata;
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
    logic [SELECT_SIZE-1:0] raddr;
    logic [DATA_WIDTH-1:0]  rdata;

    assign raddr = reg_src_i[k*SELECT_SIZE +: SELECT_SIZE];

    always_comb begin
      rdata = bank_q[raddr];
      if ((state_q == ST_CLEAR) || (raddr == '0)) begin
        rdata = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_req && !clear_i && (raddr == reg_dst_i)) begin
        rdata = data_i;
      end
`endif
    end

    assign src_o[k*DATA_WIDTH +: DATA_WIDTH] = rdata;
  end

  assign ready_o   = (state_q == ST_READY);
  assign wr_drop_o = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with four read ports.
// Expected read data comes from a bench-side register model pushed to a queue at stimulus time.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int SS = 5;
  localparam int NW = 32;
  localparam int RP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          we_n;
  logic [SS-1:0] dst;
  logic [DW-1:0] din;
  logic [RP*SS-1:0] srcs;
  logic [RP*DW-1:0] src_data;
  logic          ready;
  logic          wr_drop;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem_m [NW];
  bit            model_clear;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_WIDTH (DW),
    .WORDS      (NW),
    .SELECT_SIZE(SS),
    .READ_PORTS (RP)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (clear),
    .reg_we_ni(we_n),
    .reg_dst_i(dst),
    .data_i   (din),
    .reg_src_i(srcs),
    .src_o    (src_data),
    .ready_o  (ready),
    .wr_drop_o(wr_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_zero();
    for (int i = 0; i < NW; i++) mem_m[i] = '0;
  endtask

  // Drives the four read addresses and pushes what the model says each port must return.
  task automatic drive_reads(input logic [SS-1:0] a0, input logic [SS-1:0] a1,
                             input logic [SS-1:0] a2, input logic [SS-1:0] a3);
    logic [SS-1:0] a [RP];
    a = '{a0, a1, a2, a3};
    for (int k = 0; k < RP; k++) begin
      srcs[k*SS +: SS] = a[k];
      exp_q.push_back((model_clear || a[k] == '0) ? '0 : mem_m[a[k]]);
    end
    #1;
  endtask

  task automatic write_reg(input logic [SS-1:0] a, input logic [DW-1:0] d);
    we_n = 1'b0;
    dst  = a;
    din  = d;
    tick();
    we_n = 1'b1;
    if (!model_clear && a != '0) mem_m[a] = d;
  endtask

  task automatic count_to_ready(input int start, output int edges);
    edges = start;
    while (!ready && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    int edges;
    logic [DW-1:0] exp;
    rst_n = 1'b0; clear = 1'b0; we_n = 1'b1; dst = '0; din = '0; srcs = '0;
    model_clear = 1'b1;
    model_zero();
    #12;
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    n_checks++;
    if (wr_drop !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_drop: got %b expected 0", wr_drop); end
    @(negedge clk);
    rst_n = 1'b1;
    count_to_ready(0, edges);
    n_checks++;
    if (edges != 31) begin n_errors++; $display("[TB] FAIL reset_clear_edges: got %0d expected 31", edges); end
    model_clear = 1'b0;
    for (int base = 0; base < NW; base += RP) begin
      drive_reads(SS'(base), SS'(base + 1), SS'(base + 2), SS'(base + 3));
      for (int k = 0; k < RP; k++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (src_data[k*DW +: DW] !== exp) begin
          n_errors++;
          $display("[TB] FAIL reset_read r%0d: got %h expected %h", base + k, src_data[k*DW +: DW], exp);
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp;
    write_reg(5, 32'hDEADBEEF);
    drive_reads(5, 5, 0, 1);
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL write_r5 port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
    write_reg(0, 32'h00001234);
    n_checks++;
    if (wr_drop !== 1'b0) begin n_errors++; $display("[TB] FAIL r0_no_drop: got %b expected 0", wr_drop); end
    drive_reads(0, 5, 0, 0);
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL write_r0 port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp;
    logic [DW-1:0] exp_same;
    write_reg(7, 32'h0BADF00D);
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h0BADF00D;
`endif
    we_n = 1'b0; dst = 7; din = 32'hA5A5A5A5;
    srcs[0*SS +: SS] = 7;
    srcs[1*SS +: SS] = 7;
    srcs[2*SS +: SS] = 0;
    srcs[3*SS +: SS] = 5;
    exp_q.push_back(exp_same);
    exp_q.push_back(exp_same);
    exp_q.push_back('0);
    exp_q.push_back(mem_m[5]);
    #1;
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL same_cycle_r7 port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
    tick();
    we_n = 1'b1;
    mem_m[7] = 32'hA5A5A5A5;
    drive_reads(7, 5, 7, 0);
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL after_write_r7 port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
  endtask

  task automatic test_drop_during_clear();
    int edges;
    logic [DW-1:0] exp;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear = 1'b1;
    model_zero();
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("[TB] FAIL clear_ready_low: got %b expected 0", ready); end
    drive_reads(5, 7, 3, 0);
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL clear_masked port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
    we_n = 1'b0; dst = 3; din = 32'h33333333;
    tick();
    we_n = 1'b1;
    n_checks++;
    if (wr_drop !== 1'b1) begin n_errors++; $display("[TB] FAIL drop_pulse: got %b expected 1", wr_drop); end
    tick();
    n_checks++;
    if (wr_drop !== 1'b0) begin n_errors++; $display("[TB] FAIL drop_single: got %b expected 0", wr_drop); end
    count_to_ready(2, edges);
    n_checks++;
    if (edges != 31) begin n_errors++; $display("[TB] FAIL clear_edges: got %0d expected 31", edges); end
    model_clear = 1'b0;
    drive_reads(3, 5, 7, 1);
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL after_clear port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
  endtask

  task automatic test_clear_with_write();
    int edges;
    logic [DW-1:0] exp;
    for (int a = 1; a < NW; a++) write_reg(SS'(a), $urandom());
    drive_reads(1, 9, 31, 17);
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL filled port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
    clear = 1'b1; we_n = 1'b0; dst = 9; din = 32'hFFFF0000;
    tick();
    clear = 1'b0; we_n = 1'b1;
    model_clear = 1'b1;
    model_zero();
    n_checks++;
    if (wr_drop !== 1'b1) begin n_errors++; $display("[TB] FAIL clear_write_drop: got %b expected 1", wr_drop); end
    for (int i = 0; i < 9; i++) tick();
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("[TB] FAIL mid_clear_ready: got %b expected 0", ready); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_to_ready(0, edges);
    n_checks++;
    if (edges != 31) begin n_errors++; $display("[TB] FAIL restart_edges: got %0d expected 31", edges); end
    model_clear = 1'b0;
    for (int base = 0; base < NW; base += RP) begin
      drive_reads(SS'(base), SS'(base + 1), SS'(base + 2), SS'(base + 3));
      for (int k = 0; k < RP; k++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (src_data[k*DW +: DW] !== exp) begin
          n_errors++;
          $display("[TB] FAIL recleared r%0d: got %h expected %h", base + k, src_data[k*DW +: DW], exp);
        end
      end
    end
  endtask

  task automatic test_four_ports();
    int edges;
    logic [DW-1:0] exp;
    write_reg(1, 32'h11);
    write_reg(2, 32'h22);
    write_reg(3, 32'h33);
    drive_reads(1, 2, 3, 1);
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL four_ports port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
    write_reg(10, 32'hAAAA5555);
    write_reg(11, 32'h5555AAAA);
    drive_reads(10, 11, 2, 2);
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL back_to_back port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
    n_checks++;
    if (ready !== 1'b1) begin n_errors++; $display("[TB] FAIL pre_reset_ready: got %b expected 1", ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("[TB] FAIL async_reset_ready: got %b expected 0", ready); end
    model_clear = 1'b1;
    model_zero();
    @(negedge clk);
    rst_n = 1'b1;
    count_to_ready(0, edges);
    n_checks++;
    if (edges != 31) begin n_errors++; $display("[TB] FAIL post_reset_edges: got %0d expected 31", edges); end
    model_clear = 1'b0;
    drive_reads(1, 2, 3, 10);
    for (int k = 0; k < RP; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (src_data[k*DW +: DW] !== exp) begin
        n_errors++;
        $display("[TB] FAIL post_reset port%0d: got %h expected %h", k, src_data[k*DW +: DW], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_drop_during_clear();
    test_clear_with_write();
    test_four_ports();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
